// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

   localparam int UartDataBits = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Clock cycles per serial bit; integer division, so the baud error is the truncation.
   function automatic int bit_cycles(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock synchronous FIFO with first-word fall-through output.
// Full/empty come from the occupancy count, so pointer equality is never ambiguous.
module uart_byte_fifo #(
   parameter int Depth = 8,
   parameter int Width = 8
) (
   input  logic                   i_sys_clk,
   input  logic                   i_rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [Width-1:0]       din,
   output logic [Width-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(Depth):0] count
);

   localparam int PtrW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PtrW + 1)'(Depth));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PtrW + 1)'(1);
            2'b01:   count <= count - (PtrW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; occupancy is tracked by count and pointers,
   // so stale words are never observed and the array can map onto plain RAM.
   always_ff @(posedge i_sys_clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11-bit frame).
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int ClockFreq = 133_000_000,
   parameter int BaudRate  = 115200,
   parameter int FifoDepth = 8
) (
   input  logic                       i_sys_clk,
   input  logic                       i_rst,
   input  logic [7:0]                 i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic                       o_tx,
   output logic                       o_busy,
   output logic [$clog2(FifoDepth):0] o_fifo_count
);

   localparam int BitCycles = bit_cycles(ClockFreq, BaudRate);
   localparam int CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
   localparam int IdxW      = $clog2(UartDataBits);
   localparam logic [CntW-1:0] CntReload = CntW'(BitCycles - 1);
   localparam logic [IdxW-1:0] LastBit   = IdxW'(UartDataBits - 1);

   uart_tx_state_t          state;
   logic [CntW-1:0]         baud_cnt;
   logic [IdxW-1:0]         bit_idx;
   logic [UartDataBits-1:0] shift_reg;
   logic                    tx_reg;
   logic                    bit_done;
   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [7:0]              fifo_dout;
`ifdef UART_TX_PARITY_EN
   logic                    parity_reg;
`endif

   assign bit_done = (baud_cnt == '0);
   assign push     = i_valid && !fifo_full;
   // The frame loader takes the head byte whenever it is about to emit a start bit.
   assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));

   uart_byte_fifo #(
      .Depth (FifoDepth),
      .Width (8)
   ) u_fifo (
      .i_sys_clk (i_sys_clk),
      .i_rst     (i_rst),
      .push      (push),
      .pop       (pop),
      .din       (i_data),
      .dout      (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (o_fifo_count)
   );

   // NOTE: all state here is updated with non-blocking assignments so every branch
   // reads the pre-edge values of shift_reg, bit_idx and baud_cnt.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_reg <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx_reg <= 1'b1;
               if (!fifo_empty) begin
                  state     <= START;
                  baud_cnt  <= CntReload;
                  shift_reg <= fifo_dout;
                  tx_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  parity_reg <= ^fifo_dout;
`endif
               end
            end
            START: begin
               if (bit_done) begin
                  state    <= DATA;
                  baud_cnt <= CntReload;
                  bit_idx  <= '0;
                  tx_reg   <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt - CntW'(1);
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud_cnt <= CntReload;
                  if (bit_idx == LastBit) begin
`ifdef UART_TX_PARITY_EN
                     state  <= PARITY;
                     tx_reg <= parity_reg;
`else
                     state  <= STOP;
                     tx_reg <= 1'b1;
`endif
                  end else begin
                     bit_idx   <= bit_idx + IdxW'(1);
                     shift_reg <= shift_reg >> 1;
                     tx_reg    <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - CntW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  state    <= STOP;
                  baud_cnt <= CntReload;
                  tx_reg   <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt - CntW'(1);
               end
            end
`endif
            STOP: begin
               if (bit_done) begin
                  baud_cnt <= CntReload;
                  // Chain straight into the next start bit so frames carry no idle gap.
                  if (!fifo_empty) begin
                     state     <= START;
                     shift_reg <= fifo_dout;
                     tx_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                     parity_reg <= ^fifo_dout;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - CntW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               tx_reg <= 1'b1;
            end
         endcase
      end
   end

   assign o_tx    = tx_reg;
   assign o_ready = !fifo_full;
   assign o_busy  = (state != IDLE) || (o_fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle vector table, timing sequences and
// randomized traffic decoded off the line and compared with a byte-queue model.
module tb_uart_tx_fifo;

   localparam int ClockFreq   = 1_600_000;
   localparam int BaudRate    = 100_000;
   localparam int FifoDepth   = 8;
   localparam int Bc          = ClockFreq / BaudRate;
`ifdef UART_TX_PARITY_EN
   localparam int FrameBits   = 11;
`else
   localparam int FrameBits   = 10;
`endif
   localparam int FrameCycles = FrameBits * Bc;
   localparam int CntW        = $clog2(FifoDepth) + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      i_data = 8'h00;
   logic            i_valid = 1'b0;
   logic            o_ready;
   logic            o_tx;
   logic            o_busy;
   logic [CntW-1:0] o_fifo_count;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   logic mon_en = 1'b1;
   logic [7:0] sb[$];
   int start_times[$];

   uart_tx_fifo #(
      .ClockFreq (ClockFreq),
      .BaudRate  (BaudRate),
      .FifoDepth (FifoDepth)
   ) dut (
      .i_sys_clk    (clk),
      .i_rst        (rst),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .o_tx         (o_tx),
      .o_busy       (o_busy),
      .o_fifo_count (o_fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cycle);
      end
   endtask

   // Line level of bit k of a frame carrying byte b, from the framing rules.
   function automatic logic model_bit(input logic [7:0] b, input int k);
      int bv;
      bv = int'(b);
      if (k == 0) return 1'b0;
      if (k == FrameBits - 1) return 1'b1;
      if (k <= 8) return ((bv >> (k - 1)) % 2) == 1;
      return ($countones(b) % 2) == 1;
   endfunction

   // Line monitor: every cycle of every frame is compared with the model.
   initial begin : monitor
      logic [7:0] b;
      logic       exp_bit;
      logic       act_bit;
      logic       bad;
      forever begin
         @(negedge clk);
         if (mon_en && o_tx === 1'b0) begin
            start_times.push_back(cycle);
            if (sb.size() == 0) begin
               check("unexpected_frame", 1, 0);
               b = 8'h00;
            end else begin
               b = sb.pop_front();
            end
            for (int k = 0; k < FrameBits; k++) begin
               exp_bit = model_bit(b, k);
               act_bit = exp_bit;
               bad = 1'b0;
               for (int c = 0; c < Bc; c++) begin
                  if (k != 0 || c != 0) @(negedge clk);
                  if (!mon_en) break;
                  if (o_tx !== exp_bit) begin
                     bad = 1'b1;
                     act_bit = o_tx;
                  end
               end
               if (!mon_en) break;
               check($sformatf("frame_%02h_bit%0d", b, k), int'(act_bit), int'(exp_bit));
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic push_byte(input logic [7:0] b);
      int n;
      n = 0;
      i_data  = b;
      i_valid = 1'b1;
      while (!o_ready && n < 2 * FrameCycles) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         check("push_timeout", 0, 1);
         i_valid = 1'b0;
      end else begin
         sb.push_back(b);
         @(negedge clk);
         i_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (o_busy && n < 40 * FrameCycles) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, int'(o_busy), 0);
      repeat (3) @(negedge clk);
      check({name, "_all_sent"}, sb.size(), 0);
   endtask

   task automatic wait_starts(input string name, input int num);
      int n;
      n = 0;
      while (start_times.size() < num && n < (num + 2) * FrameCycles) begin
         @(negedge clk);
         n++;
      end
      check({name, "_starts_seen"}, int'(start_times.size() >= num), 1);
   endtask

   task automatic wait_cycle(input int target);
      while (cycle < target) @(negedge clk);
   endtask

   typedef struct {
      logic       valid;
      logic [7:0] data;
      int         count;
      logic       ready;
      logic       tx;
      logic       busy;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int s;
      int target;
      logic low_seen;
      logic [7:0] rb;

      // Cycle-by-cycle vectors from reset: one push, its pop, then three queued pushes.
      vecs[0] = '{1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 8'h55, 1, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h11, 1, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 8'h22, 2, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 8'h33, 3, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 8'h00, 3, 1'b1, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         i_valid = vecs[i].valid;
         i_data  = vecs[i].data;
         if (vecs[i].valid) sb.push_back(vecs[i].data);
         @(negedge clk);
         i_valid = 1'b0;
         check($sformatf("vec%0d_count", i), int'(o_fifo_count), vecs[i].count);
         check($sformatf("vec%0d_ready", i), int'(o_ready), int'(vecs[i].ready));
         check($sformatf("vec%0d_tx", i), int'(o_tx), int'(vecs[i].tx));
         check($sformatf("vec%0d_busy", i), int'(o_busy), int'(vecs[i].busy));
      end
      wait_idle("table");

      // Back-to-back pair: exact frame spacing and busy release after the stop bit.
      start_times.delete();
      push_byte(8'hA5);
      push_byte(8'h3C);
      wait_starts("pair", 2);
      if (start_times.size() >= 2) begin
         check("pair_spacing", start_times[1] - start_times[0], FrameCycles);
         wait_cycle(start_times[1] + FrameCycles - 1);
         check("pair_busy_in_stop", int'(o_busy), 1);
         check("pair_tx_in_stop", int'(o_tx), 1);
         @(negedge clk);
         check("pair_busy_after_stop", int'(o_busy), 0);
         check("pair_tx_after_stop", int'(o_tx), 1);
      end
      wait_idle("pair");

      // Nine consecutive pushes: the first pops at once, so ready never drops before a push.
      for (int i = 0; i < 9; i++) begin
         check($sformatf("burst9_ready%0d", i), int'(o_ready), 1);
         push_byte(8'(i));
      end
      wait_idle("burst9");

      // One frame in flight, then ten more: FIFO fills at eight, all frames contiguous.
      start_times.delete();
      push_byte(8'h80);
      for (int i = 0; i < 10; i++) begin
         if (i == 8) begin
            check("burst10_full_ready", int'(o_ready), 0);
            check("burst10_full_count", int'(o_fifo_count), FifoDepth);
         end
         push_byte(8'(8'h90 + i));
      end
      wait_idle("burst10");
      check("burst10_frames", start_times.size(), 11);
      for (int i = 1; i < start_times.size(); i++)
         check($sformatf("burst10_gap%0d", i), start_times[i] - start_times[i-1], FrameCycles);

      // Push landing on the same edge as the chained pop with four bytes queued.
      start_times.delete();
      for (int i = 0; i < 5; i++) push_byte(8'(8'h41 + i));
      check("pp_queued", int'(o_fifo_count), 4);
      wait_starts("pp", 1);
      if (start_times.size() >= 1) begin
         s = start_times[0];
         wait_cycle(s + FrameCycles - 1);
         check("pp_count_before", int'(o_fifo_count), 4);
         push_byte(8'h46);
         check("pp_count_same_edge", int'(o_fifo_count), 4);
         check("pp_next_start", int'(o_tx), 0);
      end
      wait_idle("pp");

      // Reset pulse in the middle of the data bits of 0xFF with three bytes queued.
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) push_byte((i == 0) ? 8'hFF : 8'(i));
      sb.delete();
      check("rst_queued", int'(o_fifo_count), 3);
      s = cycle;
      while (o_tx && cycle < s + 4 * Bc) @(negedge clk);
      check("rst_frame_started", int'(o_tx), 0);
      target = cycle + 4 * Bc + Bc / 2;
      wait_cycle(target);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_tx", int'(o_tx), 1);
      check("rst_count", int'(o_fifo_count), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_ready", int'(o_ready), 1);
      low_seen = 1'b0;
      for (int i = 0; i < 3 * FrameCycles; i++) begin
         @(negedge clk);
         if (o_tx !== 1'b1) low_seen = 1'b1;
      end
      check("rst_no_more_frames", int'(low_seen), 0);
      mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
      push_byte(8'h07);
      wait_idle("parity_07");
      push_byte(8'h03);
      wait_idle("parity_03");
`endif

      // Randomized traffic with random idle gaps; the monitor checks every frame.
      for (int i = 0; i < 25; i++) begin
         rb = 8'($urandom_range(0, 255));
         push_byte(rb);
         repeat ($urandom_range(0, 2 * FrameCycles)) @(negedge clk);
      end
      wait_idle("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
